// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: Tuse/Tnew codes,
// default mult/div latencies, shadow-stage records and the per-source hazard check.
package pipe_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_LINK = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    localparam int unsigned MULT_CYCLES_DEFAULT = 5;
    localparam int unsigned DIV_CYCLES_DEFAULT  = 10;

    typedef struct packed {
        logic       regwrite;
        logic [4:0] wreg;
        logic [1:0] tnew;
        logic       md_start;
        logic       md_div;
    } e_stage_t;

    typedef struct packed {
        logic       regwrite;
        logic [4:0] wreg;
        logic [1:0] tnew;
    } m_stage_t;

    function automatic int unsigned md_cnt_width(input int unsigned mult_cycles,
                                                 input int unsigned div_cycles);
        int unsigned max_cycles;
        int unsigned w;
        max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        w = $clog2(max_cycles + 1);
        return (w == 0) ? 1 : w;
    endfunction

    // A source stalls when a producer in E or M will not have its result ready
    // by the time D needs it; $0 and unused sources never stall.
    function automatic logic src_hazard(input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input e_stage_t   e,
                                        input m_stage_t   m);
        logic e_hit;
        logic m_hit;
        e_hit = e.regwrite && (e.wreg == src) && (tuse < e.tnew);
        m_hit = m.regwrite && (m.wreg == src) && (tuse < m.tnew);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// D-stage hazard information from the pipeline and the stall/bubble controls back to it.
interface pipe_hazard_ctrl_if;

    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic       d_regwrite;
    logic [4:0] d_wreg;
    logic [1:0] d_tnew;
    logic       d_md_use;
    logic       d_md_start;
    logic       d_md_div;

    logic       pc_en;
    logic       fd_en;
    logic       de_clr;
    logic       md_busy;
    logic       md_start;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_wreg, d_tnew,
               d_md_use, d_md_start, d_md_div,
        input  pc_en, fd_en, de_clr, md_busy, md_start
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_wreg, d_tnew,
               d_md_use, d_md_start, d_md_div,
        output pc_en, fd_en, de_clr, md_busy, md_start
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// Mult/div occupancy counter: busy while the op sits in E and for its latency afterwards.
module md_busy_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic e_md_start,
    input  logic e_md_div,
    input  logic d_md_use,
    output logic md_busy,
    output logic md_stall
);

    localparam int unsigned CW = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (e_md_start) begin
            cnt <= e_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign md_busy  = e_md_start | (cnt != '0);
    assign md_stall = d_md_use & md_busy;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble controller tracking E/M destination shadows against D-stage Tuse.
// Optional mult/div occupancy tracking is compiled in with MD_UNIT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave hz
);

    e_stage_t e_q;
    e_stage_t e_d;
    m_stage_t m_q;
    m_stage_t m_d;

    logic data_stall;
    logic md_stall;
    logic md_busy;
    logic stall;

    always_comb begin
        data_stall = src_hazard(hz.d_rs, hz.d_tuse_rs, e_q, m_q)
                   | src_hazard(hz.d_rt, hz.d_tuse_rt, e_q, m_q);
    end

`ifdef MD_UNIT_EN
    md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_tracker (
        .clk        (clk),
        .reset      (reset),
        .e_md_start (e_q.md_start),
        .e_md_div   (e_q.md_div),
        .d_md_use   (hz.d_md_use),
        .md_busy    (md_busy),
        .md_stall   (md_stall)
    );
`else
    logic md_inputs_unused;
    assign md_inputs_unused = hz.d_md_use ^ hz.d_md_div ^ e_q.md_div;
    assign md_busy  = 1'b0;
    assign md_stall = 1'b0;
`endif

    assign stall = data_stall | md_stall;

    // E takes a bubble while D is held; M always follows E with Tnew aged by one.
    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.regwrite = hz.d_regwrite;
            e_d.wreg     = hz.d_wreg;
            e_d.tnew     = hz.d_tnew;
            e_d.md_start = hz.d_md_start;
`ifdef MD_UNIT_EN
            e_d.md_div   = hz.d_md_div;
`endif
        end

        m_d          = '0;
        m_d.regwrite = e_q.regwrite;
        m_d.wreg     = e_q.wreg;
        m_d.tnew     = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
        end
    end

    assign hz.pc_en    = ~stall;
    assign hz.fd_en    = ~stall;
    assign hz.de_clr   = stall;
    assign hz.md_busy  = md_busy;
    assign hz.md_start = e_q.md_start;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; MD-unit checks follow MD_UNIT_EN.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hif ();

    pipe_hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

`ifdef MD_UNIT_EN
    localparam logic MD_ON = 1'b1;
`else
    localparam logic MD_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic exp_stall,
                           input logic exp_busy, input logic exp_start);
        chk({tag, "/pc_en"},    hif.pc_en,    ~exp_stall);
        chk({tag, "/fd_en"},    hif.fd_en,    ~exp_stall);
        chk({tag, "/de_clr"},   hif.de_clr,   exp_stall);
        chk({tag, "/md_busy"},  hif.md_busy,  exp_busy);
        chk({tag, "/md_start"}, hif.md_start, exp_start);
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
                         input logic rw, input logic [4:0] wreg, input logic [1:0] tnew,
                         input logic md_use, input logic md_start, input logic md_div);
        hif.d_rs       = rs;
        hif.d_rt       = rt;
        hif.d_tuse_rs  = tuse_rs;
        hif.d_tuse_rt  = tuse_rt;
        hif.d_regwrite = rw;
        hif.d_wreg     = wreg;
        hif.d_tnew     = tnew;
        hif.d_md_use   = md_use;
        hif.d_md_start = md_start;
        hif.d_md_div   = md_div;
        #1;
    endtask

    task automatic nop();
        set_d(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        for (int i = 0; i < 12; i++) tick();
    endtask

    initial begin
        nop();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_out("reset", 0, 0, 0);

        // lw $1 then addu rs=1 tuse 1: one stall
        set_d(0, 0, 3, 3, 1, 1, 2, 0, 0, 0);
        chk_out("lu1_issue", 0, 0, 0);
        tick();
        set_d(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
        chk_out("lu1_stall", 1, 0, 0);
        tick();
        chk_out("lu1_release", 0, 0, 0);
        tick();
        flush();

        // lw $1 then beq rt=1 tuse 0: two stalls
        set_d(0, 0, 3, 3, 1, 1, 2, 0, 0, 0);
        tick();
        set_d(0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        chk_out("lu0_stall1", 1, 0, 0);
        tick();
        chk_out("lu0_stall2", 1, 0, 0);
        tick();
        chk_out("lu0_release", 0, 0, 0);
        tick();
        flush();

        // ALU $1 then beq rs=1 tuse 0: one stall
        set_d(0, 0, 3, 3, 1, 1, 1, 0, 0, 0);
        tick();
        set_d(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk_out("alu0_stall", 1, 0, 0);
        tick();
        chk_out("alu0_release", 0, 0, 0);
        tick();
        flush();

        // ALU $1 then tuse 1: ready in time
        set_d(0, 0, 3, 3, 1, 1, 1, 0, 0, 0);
        tick();
        set_d(1, 0, 1, 3, 1, 2, 1, 0, 0, 0);
        chk_out("alu1_nostall", 0, 0, 0);
        flush();

        // writes to $0 never stall
        set_d(0, 0, 3, 3, 1, 0, 2, 0, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_out("reg0", 0, 0, 0);
        flush();

        // matching wreg without regwrite
        set_d(0, 0, 3, 3, 0, 1, 2, 0, 0, 0);
        tick();
        set_d(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk_out("noregwrite", 0, 0, 0);
        flush();

        // tuse 3 means unused
        set_d(0, 0, 3, 3, 1, 1, 2, 0, 0, 0);
        tick();
        set_d(1, 1, 3, 3, 0, 0, 0, 0, 0, 0);
        chk_out("tuse_none", 0, 0, 0);
        flush();

        // different register
        set_d(0, 0, 3, 3, 1, 5, 2, 0, 0, 0);
        tick();
        set_d(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk_out("other_reg", 0, 0, 0);
        flush();

        // hazard held only in M
        set_d(0, 0, 3, 3, 1, 2, 2, 0, 0, 0);
        tick();
        set_d(0, 0, 3, 3, 1, 9, 1, 0, 0, 0);
        chk_out("m_only_gap", 0, 0, 0);
        tick();
        set_d(2, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk_out("m_only_stall", 1, 0, 0);
        tick();
        chk_out("m_only_release", 0, 0, 0);
        tick();
        flush();

        // same register hazard in E and M at once
        set_d(0, 0, 3, 3, 1, 3, 2, 0, 0, 0);
        tick();
        set_d(0, 0, 3, 3, 1, 3, 2, 0, 0, 0);
        chk_out("em_second_lw", 0, 0, 0);
        tick();
        set_d(3, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk_out("em_stall1", 1, 0, 0);
        tick();
        chk_out("em_stall2", 1, 0, 0);
        tick();
        chk_out("em_release", 0, 0, 0);
        tick();
        flush();

        // link result (tnew 0) never stalls
        set_d(0, 0, 3, 3, 1, 31, 0, 0, 0, 0);
        tick();
        set_d(31, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk_out("link", 0, 0, 0);
        flush();

        // data stall while mult is in E still starts the op
        set_d(0, 0, 3, 3, 1, 1, 2, 0, 0, 0);
        tick();
        set_d(0, 0, 3, 3, 0, 0, 0, 1, 1, 0);
        chk_out("mult_issue", 0, 0, 0);
        tick();
        set_d(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        chk_out("stall_with_start", 1, MD_ON, 1);
        tick();
        chk_out("stall_with_start_next", 0, MD_ON, 0);
        tick();
        flush();

`ifdef MD_UNIT_EN
        // mult then mflo: MULT_CYCLES+1 stalls
        set_d(0, 0, 3, 3, 0, 0, 0, 1, 1, 0);
        chk_out("md_mult_issue", 0, 0, 0);
        tick();
        set_d(0, 0, 3, 3, 1, 8, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            chk_out($sformatf("md_mult_stall%0d", i), 1, 1, (i == 0));
            tick();
        end
        chk_out("md_mult_release", 0, 0, 0);
        tick();
        flush();

        // div then mflo: DIV_CYCLES+1 stalls
        set_d(0, 0, 3, 3, 0, 0, 0, 1, 1, 1);
        tick();
        set_d(0, 0, 3, 3, 1, 8, 1, 1, 0, 0);
        for (int i = 0; i < 11; i++) begin
            chk_out($sformatf("md_div_stall%0d", i), 1, 1, (i == 0));
            tick();
        end
        chk_out("md_div_release", 0, 0, 0);
        tick();
        flush();

        // reset three cycles into a div aborts occupancy
        set_d(0, 0, 3, 3, 0, 0, 0, 1, 1, 1);
        tick();
        nop();
        chk_out("md_div_no_use", 0, 1, 1);
        tick();
        tick();
        tick();
        chk_out("md_div_busy_mid", 0, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_d(0, 0, 3, 3, 1, 8, 1, 1, 0, 0);
        chk_out("md_reset_abort", 0, 0, 0);
        flush();
`else
        // without the MD unit, mult then mflo never stalls but md_start still pulses
        set_d(0, 0, 3, 3, 0, 0, 0, 1, 1, 0);
        chk_out("nomd_mult_issue", 0, 0, 0);
        tick();
        set_d(0, 0, 3, 3, 1, 8, 1, 1, 0, 0);
        chk_out("nomd_mflo", 0, 0, 1);
        tick();
        chk_out("nomd_mflo_next", 0, 0, 0);
        tick();
        flush();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Stall and bubble controller for the five-stage pipeline. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and tracks in-flight destination registers and result-ready times (Tnew) in its own E and M shadow stages. It compares them against the D-stage source use times (Tuse) and also tracks multi-cycle mult/div occupancy. From this it drives PC/IF-ID enables and the ID/EX bubble clear.

## Interface

- MULT_CYCLES, default 5: busy cycles after a mult/multu leaves E.
- DIV_CYCLES, default 10: busy cycles after a div/divu leaves E.

Ports (clock and reset first):

- clk, input, 1: clock, all state on rising edge.
- reset, input, 1: reset, synchronous, active-high.
- d_rs, input, 5: D-stage rs address.
- d_rt, input, 5: D-stage rt address.
- d_tuse_rs, input, 2: cycles until D needs rs; 3 = unused.
- d_tuse_rt, input, 2: cycles until D needs rt; 3 = unused.
- d_regwrite, input, 1: D instruction writes the GPR file.
- d_wreg, input, 5: D destination register.
- d_tnew, input, 2: Tnew at E entry (link 0, ALU 1, load 2).
- d_md_use, input, 1: D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- d_md_start, input, 1: D instruction is mult/multu/div/divu.
- d_md_div, input, 1: with d_md_start, 1 = divide.
- pc_en, output, 1: PC write enable.
- fd_en, output, 1: IF/ID write enable.
- de_clr, output, 1: clear ID/EX (insert bubble).
- md_busy, output, 1: mult/div unit occupied.
- md_start, output, 1: start pulse to mult/div unit, high while op in E.

## Operation

E shadow stage:
- Fields: e_regwrite, e_wreg, e_tnew, e_md_start, e_md_div.
- Loads from D when not stalled.
- Loads all-zero (bubble) when stall=1.

M shadow stage:
- Fields: m_regwrite, m_wreg, m_tnew.
- Always loads from E.
- m_tnew = e_tnew-1, saturating at 0.

Data stall, rs (rt identical with d_rt/d_tuse_rt):
- Stall if d_rs!=0, and either:
  - e_regwrite and e_wreg==d_rs and d_tuse_rs<e_tnew, or
  - m_regwrite and m_wreg==d_rs and d_tuse_rs<m_tnew.
- tuse=3 never stalls.

Mult/div tracking:
- Counter loads MULT_CYCLES or DIV_CYCLES (per e_md_div) on the edge when e_md_start=1.
- Otherwise decrements to 0 and holds.
- md_busy = e_md_start | (cnt!=0).
- md_stall = d_md_use & md_busy.
- md_start = e_md_start; bubbles never start an op.

Outputs:
- stall = data_stall | md_stall.
- pc_en = fd_en = ~stall.
- de_clr = stall.
- E→M flow is never stalled.

Reset:
- Clears the shadow stages and the counter.
- Outputs after reset: pc_en=1, fd_en=1, de_clr=0, md_busy=0, md_start=0.
- Reset mid-count aborts occupancy immediately.

Simultaneous events:
- A stall with md_start=1 still starts the op.
- Hazards in both E and M on one register give one stall.
- Register 0 never stalls.

## Timing

- Outputs are combinational from registered state plus current D inputs, valid in the same cycle.
- Shadow stages and counter update on the rising edge.
- Load-use with tuse 1: 1 stall cycle.
- Load-use with tuse 0: 2 stall cycles.
- ALU result with tuse 0: 1 stall cycle.
- mult then dependent MD op in D during the mult's E cycle: MULT_CYCLES+1 stall cycles. Div: DIV_CYCLES+1.
- Counter width: clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Configuration

MD_UNIT_EN:
- Defined: the mult/div counter and md_stall are compiled in.
- Undefined:
  - The counter is removed, md_stall=0 and md_busy=0.
  - md_start still mirrors e_md_start.
  - d_md_use and d_md_div are ignored.

## Structure

- Shared package pipe_ctrl_pkg:
  - TUSE_NONE=3, TNEW_LINK=0, TNEW_ALU=1, TNEW_LOAD=2.
  - Default MULT_CYCLES and DIV_CYCLES.
- Sub-module md_busy_tracker:
  - Contains the counter, md_busy and md_stall.
  - Instantiated only under MD_UNIT_EN.

## Test plan

- lw $1 (tnew 2), then addu rs=1 tuse 1 -> pc_en=0 and de_clr=1 for exactly 1 cycle, then released.
- lw $1, then beq rs=1 tuse 0 -> 2 stall cycles; ALU write $1 then beq -> 1 stall cycle.
- E writes $0 (regwrite=1, tnew 2), D reads rs=0 tuse 0 -> no stall.
- mult in E at cycle t with mflo in D -> stall cycles t..t+5 (6 cycles), md_start=1 only at t; div -> 11 cycles.
- reset asserted 3 cycles into a div -> next cycle md_busy=0, mflo in D does not stall.
- Built without MD_UNIT_EN: mult then mflo -> no stall, md_busy=0, md_start still pulses.
